// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: op codes, FSM states, error
// causes and byte-lane helpers. Timeout abort is enabled with MEM_TIMEOUT_EN.
package mem_ctrl_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    // op[1:0] is the access size, op[2] selects zero-extension, op[3] marks a store
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_HALF: return lane[0];
            SZ_WORD: return |lane;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return BE_BYTE0 << lane;
            SZ_HALF: return lane[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_ext_unit.sv
// Combinational lane select and sign/zero extension of a loaded memory word.
// Not affected by MEM_TIMEOUT_EN.
module load_ext_unit
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [3:0]  i_op,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        o_result = i_word;
        case (i_op)
            OP_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_result = {24'b0, w_byte};
            OP_LH:   o_result = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_result = {16'b0, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer between the execute/memory stage and the
// data-memory port. Define MEM_TIMEOUT_EN to abort unacknowledged requests.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_cause,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Memory handshake: mem_req is the valid, mem_ack the ready. Address, lanes,
    // we and write data stay stable while mem_req is high; the transfer happens
    // on the edge where both are high and mem_req drops on that same edge.

    state_t      r_state;
    logic [3:0]  r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_word;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_cause;
    logic [31:0] r_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] w_ext;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_cnt;
`endif

    load_ext_unit u_ext (
        .i_word   (r_word),
        .i_lane   (r_lane),
        .i_op     (r_op),
        .o_result (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= 4'b0;
            r_lane      <= 2'b0;
            r_word      <= 32'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cause <= ERR_NONE;
            r_rdata     <= 32'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'b0;
            r_mem_be    <= 4'b0;
            r_mem_wdata <= 32'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cause <= ERR_NONE;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_lane <= addr[1:0];
                        r_busy <= 1'b1;
                        // Illegal op is reported ahead of misalignment
                        if (!op_legal(op)) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_err       <= 1'b1;
                            r_err_cause <= ERR_ILLEGAL;
                        end else if (op_misaligned(op[1:0], addr[1:0])) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_err       <= 1'b1;
                            r_err_cause <= ERR_MISALIGN;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= op[3];
                            r_mem_addr  <= {addr[31:2], 2'b00};
                            r_mem_be    <= lane_be(op[1:0], addr[1:0]);
                            r_mem_wdata <= lane_wdata(op[1:0], wdata);
`ifdef MEM_TIMEOUT_EN
                            r_cnt       <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_op[3]) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_word  <= mem_rdata;
                            r_state <= S_EXT;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (r_cnt == CNT_LAST) begin
                        r_mem_req   <= 1'b0;
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                        r_err_cause <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    end
`endif
                end
                S_EXT: begin
                    r_rdata <= w_ext;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_cause = r_err_cause;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: randomized commands against a
// transaction-level model, plus directed cases with literal expectations.
module tb_mem_access_ctrl;
  localparam int TMO = 16;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_cause;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cause (err_cause),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- model state / scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  logic exp_rst_vals = 1'b0;
  logic exp_busy = 1'b0, exp_done = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_rdata = 32'h0, exp_maddr = 32'h0, exp_wd = 32'h0;
  logic [3:0]  exp_be = 4'h0;
  logic [2:0]  exp_q[$];
  logic [2:0]  e;
  logic [3:0]  legal_ops [8] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};

  int req_cnt = 0, done_cnt = 0, obs_done_cyc = 0;
  int cmd_start_cyc = 0, cmd_req0 = 0;
  logic [31:0] obs_rdata = 0, obs_maddr = 0, obs_wd = 0;
  logic [3:0]  obs_be = 0;
  logic        obs_we = 0, obs_err = 0;
  logic [1:0]  obs_cause = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] o);
    for (int i = 0; i < 8; i++) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int size_of(input logic [3:0] o);
    case (o & 4'b0011)
      4'd0:    return 1;
      4'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w);
    int unsigned n, bits, v;
    n = size_of(o);
    bits = 8 * n;
    v = w >> (8 * a[1:0]);
    if (n == 4) return v;
    v = v % (32'd1 << bits);
    if (o[2] == 1'b0 && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] o, input logic [31:0] a);
    int unsigned n;
    n = size_of(o);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wd(input logic [3:0] o, input logic [31:0] w);
    case (size_of(o))
      1:       return (w & 32'hFF) * 32'h01010101;
      2:       return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      check("rdata", rdata, exp_rdata);
      if (exp_req) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr, exp_maddr);
        check("mem_be", 32'(mem_be), 32'(exp_be));
        if (exp_we) check("mem_wdata", mem_wdata, exp_wd);
      end
      if (mem_req) begin
        req_cnt++;
        obs_be = mem_be;
        obs_maddr = mem_addr;
        obs_wd = mem_wdata;
        obs_we = mem_we;
      end
      if (done) begin
        done_cnt++;
        obs_done_cyc = cyc;
        obs_rdata = rdata;
        obs_err = err;
        obs_cause = err_cause;
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err", 32'(err), 32'(e[2]));
          check("err_cause", 32'(err_cause), 32'(e[1:0]));
        end
      end
      if (exp_rst_vals) begin
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cause", 32'(err_cause), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic dn, input logic rq);
    exp_busy = b;
    exp_done = dn;
    exp_req = rq;
  endtask

  task automatic noise();
    start = 1'($urandom_range(0, 1));
    op = 4'($urandom);
    addr = $urandom;
    wdata = $urandom;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  task automatic idle_step();
    noise();
    start = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
  endtask

  // Issues one command in the current IDLE cycle; d = REQ cycles without ack before the ack.
  task automatic run_cmd(input logic [3:0] c_op, input logic [31:0] c_addr,
                         input logic [31:0] c_wdata, input logic [31:0] c_word, input int d);
    int n, nreq;
    bit legal, tmo;
    legal = is_legal(c_op);
    n = size_of(c_op);
    start = 1'b1;
    op = c_op;
    addr = c_addr;
    wdata = c_wdata;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    cmd_req0 = req_cnt;
    step();
    cmd_start_cyc = cyc;
    if (!legal || (c_addr % n) != 0) begin
      exp_q.push_back({1'b1, legal ? 2'b01 : 2'b10});
      set_exp(1'b1, 1'b1, 1'b0);
      noise();
      step();
    end else begin
      exp_we = c_op[3];
      exp_maddr = c_addr & 32'hFFFF_FFFC;
      exp_be = model_be(c_op, c_addr);
      exp_wd = model_wd(c_op, c_wdata);
      tmo = TMO_EN && (d >= TMO);
      nreq = tmo ? TMO : d + 1;
      for (int k = 1; k <= nreq; k++) begin
        set_exp(1'b1, 1'b0, 1'b1);
        noise();
        mem_ack = (!tmo && k == d + 1);
        if (mem_ack) mem_rdata = c_word;
        step();
      end
      if (tmo) begin
        exp_q.push_back(3'b111);
        set_exp(1'b1, 1'b1, 1'b0);
        noise();
        step();
      end else if (c_op[3]) begin
        exp_q.push_back(3'b000);
        set_exp(1'b1, 1'b1, 1'b0);
        noise();
        step();
      end else begin
        set_exp(1'b1, 1'b0, 1'b0);
        noise();
        step();
        exp_q.push_back(3'b000);
        exp_rdata = model_load(c_op, c_addr, c_word);
        set_exp(1'b1, 1'b1, 1'b0);
        noise();
        step();
      end
    end
    set_exp(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_mid();
    int d0;
    start = 1'b1;
    op = 4'h3;
    addr = 32'h80;
    wdata = $urandom;
    mem_ack = 1'b0;
    step();
    exp_we = 1'b0;
    exp_maddr = 32'h80;
    exp_be = 4'hF;
    for (int k = 0; k < 3; k++) begin
      set_exp(1'b1, 1'b0, 1'b1);
      noise();
      mem_ack = 1'b0;
      step();
    end
    rst = 1'b1;
    set_exp(1'b1, 1'b0, 1'b1);
    noise();
    start = 1'b0;
    mem_ack = 1'b0;
    d0 = done_cnt;
    step();
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    exp_rdata = 32'h0;
    exp_rst_vals = 1'b1;
    start = 1'b0;
    mem_ack = 1'b1;
    step();
    exp_rst_vals = 1'b0;
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  r_o;
    logic [31:0] r_a;
    int          r_d;
    rst = 1'b1;
    start = 1'b0;
    op = 4'h0;
    addr = 32'h0;
    wdata = 32'h0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(posedge clk);
    #1;
    exp_rst_vals = 1'b1;
    chk_en = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    exp_rst_vals = 1'b0;

    run_cmd(4'h0, 32'h1003, 32'h0, 32'h80FF7F01, 0);
    check("lb_be", 32'(obs_be), 32'b1000);
    check("lb_latency", 32'(obs_done_cyc - cmd_start_cyc + 1), 32'd3);
    check("lb_rdata", obs_rdata, 32'hFFFFFF80);

    run_cmd(4'h5, 32'h2002, 32'h0, 32'hBEEF1234, 1);
    check("lhu_rdata", obs_rdata, 32'h0000BEEF);
    run_cmd(4'h1, 32'h2002, 32'h0, 32'hBEEF1234, 2);
    check("lh_rdata", obs_rdata, 32'hFFFFBEEF);
    check("lh_latency", 32'(obs_done_cyc - cmd_start_cyc + 1), 32'd5);

    run_cmd(4'h8, 32'h11, 32'h000000A5, $urandom, 0);
    check("sb_addr", obs_maddr, 32'h10);
    check("sb_be", 32'(obs_be), 32'b0010);
    check("sb_wdata", obs_wd, 32'hA5A5A5A5);
    check("sb_we", 32'(obs_we), 32'd1);
    check("sb_latency", 32'(obs_done_cyc - cmd_start_cyc + 1), 32'd2);
    check("sb_rdata_hold", rdata, 32'hFFFFBEEF);

    run_cmd(4'h9, 32'h22, 32'h1234ABCD, $urandom, 0);
    check("sh_be", 32'(obs_be), 32'b1100);
    check("sh_wdata", obs_wd, 32'hABCDABCD);

    run_cmd(4'h3, 32'h6, 32'h0, $urandom, 0);
    check("lw_mis_latency", 32'(obs_done_cyc - cmd_start_cyc + 1), 32'd1);
    check("lw_mis_cause", 32'(obs_cause), 32'b01);
    check("lw_mis_no_req", 32'(req_cnt - cmd_req0), 32'd0);
    run_cmd(4'h7, 32'h6, 32'h0, $urandom, 0);
    check("illegal_cause", 32'(obs_cause), 32'b10);
    check("illegal_err", 32'(obs_err), 32'd1);
    check("illegal_no_req", 32'(req_cnt - cmd_req0), 32'd0);

    run_cmd(4'h3, 32'h40, 32'h0, 32'h12345678, 100);
`ifdef MEM_TIMEOUT_EN
    check("tmo_req_cycles", 32'(req_cnt - cmd_req0), 32'd16);
    check("tmo_cause", 32'(obs_cause), 32'b11);
    check("tmo_latency", 32'(obs_done_cyc - cmd_start_cyc + 1), 32'd17);
`else
    check("notmo_req_cycles", 32'(req_cnt - cmd_req0), 32'd101);
    check("notmo_rdata", obs_rdata, 32'h12345678);
`endif
    run_cmd(4'h3, 32'h44, 32'h0, 32'hCAFEF00D, TMO - 1);
    check("ack_at_limit_rdata", obs_rdata, 32'hCAFEF00D);
    check("ack_at_limit_err", 32'(obs_err), 32'd0);

    reset_mid();
    run_cmd(4'h3, 32'h80, 32'h0, 32'h0BADBEEF, 0);
    check("after_rst_rdata", obs_rdata, 32'h0BADBEEF);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 8) r_o = legal_ops[$urandom_range(0, 7)];
      else r_o = 4'($urandom);
      r_a = $urandom;
      if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
      r_d = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) r_d = $urandom_range(4, TMO + 4);
      run_cmd(r_o, r_a, $urandom, $urandom, r_d);
      repeat ($urandom_range(0, 2)) idle_step();
    end

    repeat (3) idle_step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
